// File: rtl/life_pkg.sv
// Shared types and constants for the Life-like grid engine.
package life_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [8:0] CONWAY_BIRTH   = 9'h008;
  localparam logic [8:0] CONWAY_SURVIVE = 9'h00C;

  // Neighbour count 0..8
  localparam int NCNT_W = 4;

endpackage

// File: rtl/life_row_next.sv
// Combinational next-row evaluation for one grid row of a Life-like rule.
// With LIFE_POPCOUNT_EN defined, also reports the live-cell count of the new row.
module life_row_next
  import life_pkg::*;
#(
  parameter int M = 64
) (
  input  logic [M-1:0] above,
  input  logic [M-1:0] cur,
  input  logic [M-1:0] below,
  input  logic         wrap,
  input  logic [8:0]   rule_birth,
  input  logic [8:0]   rule_survive,
  output logic [M-1:0] next_row
`ifdef LIFE_POPCOUNT_EN
  ,
  output logic [$clog2(M+1)-1:0] row_pop
`endif
);

  // bit c of *_l holds column c-1, bit c of *_r holds column c+1; edges wrap or read dead
  logic [M-1:0] a_l, a_r, c_l, c_r, b_l, b_r;
  logic [NCNT_W-1:0] cnt;

  assign a_l = {above[M-2:0], wrap & above[M-1]};
  assign a_r = {wrap & above[0], above[M-1:1]};
  assign c_l = {cur[M-2:0], wrap & cur[M-1]};
  assign c_r = {wrap & cur[0], cur[M-1:1]};
  assign b_l = {below[M-2:0], wrap & below[M-1]};
  assign b_r = {wrap & below[0], below[M-1:1]};

  always_comb begin
    next_row = '0;
    cnt      = '0;
    for (int c = 0; c < M; c++) begin
      cnt = NCNT_W'(a_l[c]) + NCNT_W'(above[c]) + NCNT_W'(a_r[c]) +
            NCNT_W'(c_l[c]) + NCNT_W'(c_r[c]) +
            NCNT_W'(b_l[c]) + NCNT_W'(below[c]) + NCNT_W'(b_r[c]);
      next_row[c] = cur[c] ? rule_survive[cnt] : rule_birth[cnt];
    end
  end

`ifdef LIFE_POPCOUNT_EN
  localparam int RPW = $clog2(M+1);

  always_comb begin
    row_pop = '0;
    for (int c = 0; c < M; c++) row_pop = row_pop + RPW'(next_row[c]);
  end
`endif

endmodule

// File: rtl/life_grid_engine.sv
// N x M Life-like grid engine: row-serial update, one row per clock, programmable rule.
// Optional LIFE_POPCOUNT_EN adds pop_count_o and ends a run early on extinction.
module life_grid_engine
  import life_pkg::*;
#(
  parameter int M     = 64,
  parameter int N     = 64,
  parameter int GEN_W = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 load_valid_i,
  output logic                 load_ready_o,
  input  logic [M-1:0]         load_row_i,
  input  logic                 start_i,
  input  logic [GEN_W-1:0]     step_count_i,
  input  logic                 abort_i,
  input  logic [8:0]           rule_birth_i,
  input  logic [8:0]           rule_survive_i,
  input  logic                 wrap_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [GEN_W-1:0]     gen_count_o,
  input  logic [$clog2(N)-1:0] rd_row_idx_i,
  output logic [M-1:0]         rd_row_o
`ifdef LIFE_POPCOUNT_EN
  ,
  output logic [$clog2(M*N+1)-1:0] pop_count_o
`endif
);

  localparam int RW = $clog2(N);
  localparam logic [RW-1:0] LAST_ROW = RW'(N-1);

  state_t           state;
  logic [M-1:0]     grid [N];
  logic [RW-1:0]    load_ptr, row_ptr, below_idx;
  logic [M-1:0]     prev_orig, row0_orig, above_row, cur_row, below_row, next_row;
  logic [8:0]       birth_q, survive_q;
  logic             wrap_q, abort_q;
  logic [GEN_W-1:0] k_q, gens_done;
  logic             load_fire, last_row, gen_last, stop_run;

  assign load_fire = load_valid_i & load_ready_o;
  assign last_row  = (row_ptr == LAST_ROW);
  assign below_idx = last_row ? '0 : row_ptr + 1'b1;
  assign gen_last  = ((gens_done + 1'b1) == k_q);

  // Rows above r are already overwritten, so the old values come from prev_orig/row0_orig
  assign above_row = (row_ptr == '0) ? (wrap_q ? grid[N-1] : '0) : prev_orig;
  assign cur_row   = grid[row_ptr];
  assign below_row = last_row ? (wrap_q ? row0_orig : '0) : grid[below_idx];

`ifdef LIFE_POPCOUNT_EN
  localparam int PW  = $clog2(M*N+1);
  localparam int RPW = $clog2(M+1);
  logic [RPW-1:0] row_pop;
  logic [PW-1:0]  pop_acc, pop_total;

  assign pop_total = pop_acc + PW'(row_pop);
  assign stop_run  = gen_last | abort_q | abort_i | (pop_total == '0);
`else
  assign stop_run  = gen_last | abort_q | abort_i;
`endif

  life_row_next #(.M(M)) u_row_next (
    .above        (above_row),
    .cur          (cur_row),
    .below        (below_row),
    .wrap         (wrap_q),
    .rule_birth   (birth_q),
    .rule_survive (survive_q),
    .next_row     (next_row)
`ifdef LIFE_POPCOUNT_EN
    ,
    .row_pop      (row_pop)
`endif
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state        <= ST_IDLE;
      load_ready_o <= 1'b1;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      for (int r = 0; r < N; r++) grid[r] <= '0;
      load_ptr     <= '0;
      row_ptr      <= '0;
      prev_orig    <= '0;
      row0_orig    <= '0;
      birth_q      <= CONWAY_BIRTH;
      survive_q    <= CONWAY_SURVIVE;
      wrap_q       <= 1'b0;
      abort_q      <= 1'b0;
      k_q          <= '0;
      gens_done    <= '0;
      gen_count_o  <= '0;
`ifdef LIFE_POPCOUNT_EN
      pop_acc      <= '0;
      pop_count_o  <= '0;
`endif
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (load_fire) begin
            grid[load_ptr] <= load_row_i;
            load_ptr       <= (load_ptr == LAST_ROW) ? '0 : load_ptr + 1'b1;
            if (load_ptr == '0) begin
              gen_count_o <= '0;
`ifdef LIFE_POPCOUNT_EN
              pop_count_o <= '0;
`endif
            end
          end
          if (start_i) begin
            birth_q   <= rule_birth_i;
            survive_q <= rule_survive_i;
            wrap_q    <= wrap_i;
            k_q       <= step_count_i;
            gens_done <= '0;
            abort_q   <= 1'b0;
            row_ptr   <= '0;
`ifdef LIFE_POPCOUNT_EN
            pop_acc   <= '0;
`endif
            if (step_count_i == '0) begin
              done_o <= 1'b1;
            end else begin
              state        <= ST_RUN;
              busy_o       <= 1'b1;
              load_ready_o <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          if (abort_i) abort_q <= 1'b1;
          grid[row_ptr] <= next_row;
          prev_orig     <= cur_row;
          if (row_ptr == '0) row0_orig <= cur_row;
          if (last_row) begin
            row_ptr     <= '0;
            gen_count_o <= gen_count_o + 1'b1;
            gens_done   <= gens_done + 1'b1;
`ifdef LIFE_POPCOUNT_EN
            pop_count_o <= pop_total;
            pop_acc     <= '0;
`endif
            if (stop_run) begin
              state        <= ST_IDLE;
              done_o       <= 1'b1;
              busy_o       <= 1'b0;
              load_ready_o <= 1'b1;
            end
          end else begin
            row_ptr <= row_ptr + 1'b1;
`ifdef LIFE_POPCOUNT_EN
            pop_acc <= pop_total;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)               rd_row_o <= '0;
    else if (int'(rd_row_idx_i) < N) rd_row_o <= grid[rd_row_idx_i];
    else                          rd_row_o <= '0;
  end

endmodule

// File: tb/tb_life_grid_engine.sv
// Self-checking bench for life_grid_engine on an 8-column x 6-row grid.
`timescale 1ns/1ps
module tb_life_grid_engine;
  import life_pkg::*;

  localparam int M     = 8;
  localparam int N     = 6;
  localparam int GEN_W = 16;
  localparam int RW    = $clog2(N);

  logic             clk_i = 1'b0;
  logic             reset_n_i;
  logic             load_valid_i;
  logic             load_ready_o;
  logic [M-1:0]     load_row_i;
  logic             start_i;
  logic [GEN_W-1:0] step_count_i;
  logic             abort_i;
  logic [8:0]       rule_birth_i, rule_survive_i;
  logic             wrap_i;
  logic             busy_o, done_o;
  logic [GEN_W-1:0] gen_count_o;
  logic [RW-1:0]    rd_row_idx_i;
  logic [M-1:0]     rd_row_o;
`ifdef LIFE_POPCOUNT_EN
  logic [$clog2(M*N+1)-1:0] pop_count_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [M-1:0] mgrid    [N];
  logic [M-1:0] exp_rows [N];
  logic [M-1:0] exp_q [$];

  always #5 clk_i = ~clk_i;

  life_grid_engine #(.M(M), .N(N), .GEN_W(GEN_W)) dut (
    .clk_i          (clk_i),
    .reset_n_i      (reset_n_i),
    .load_valid_i   (load_valid_i),
    .load_ready_o   (load_ready_o),
    .load_row_i     (load_row_i),
    .start_i        (start_i),
    .step_count_i   (step_count_i),
    .abort_i        (abort_i),
    .rule_birth_i   (rule_birth_i),
    .rule_survive_i (rule_survive_i),
    .wrap_i         (wrap_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .gen_count_o    (gen_count_o),
    .rd_row_idx_i   (rd_row_idx_i),
    .rd_row_o       (rd_row_o)
`ifdef LIFE_POPCOUNT_EN
    ,
    .pop_count_o    (pop_count_o)
`endif
  );

  // Reference: explicit 8-neighbour scan over the whole grid
  task automatic model_step(input logic [8:0] b, input logic [8:0] s, input logic w);
    logic [M-1:0] nxt [N];
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < M; c++) begin
        int cnt;
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            int rr, cc;
            bit ok;
            rr = r + dr;
            cc = c + dc;
            if (w) begin
              rr = (rr + N) % N;
              cc = (cc + M) % M;
              ok = 1'b1;
            end else begin
              ok = (rr >= 0 && rr < N && cc >= 0 && cc < M);
            end
            if (ok && !(dr == 0 && dc == 0) && mgrid[rr][cc]) cnt++;
          end
        end
        nxt[r][c] = mgrid[r][c] ? s[cnt] : b[cnt];
      end
    end
    mgrid = nxt;
  endtask

  task automatic clear_model();
    for (int r = 0; r < N; r++) mgrid[r] = '0;
  endtask

  task automatic push_expect();
    for (int r = 0; r < N; r++) exp_q.push_back(exp_rows[r]);
    for (int r = N; r < (1 << RW); r++) exp_q.push_back('0);
  endtask

  task automatic load_grid(input int nrows);
    for (int r = 0; r < nrows; r++) begin
      @(negedge clk_i);
      load_valid_i = 1'b1;
      load_row_i   = mgrid[r];
      @(posedge clk_i);
    end
    @(negedge clk_i);
    load_valid_i = 1'b0;
  endtask

  task automatic check_grid(input string name);
    logic [M-1:0] exp;
    for (int r = 0; r < (1 << RW); r++) begin
      @(negedge clk_i);
      rd_row_idx_i = RW'(r);
      @(posedge clk_i);
      @(negedge clk_i);
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s row %0d: scoreboard empty, got %b", name, r, rd_row_o);
      end else begin
        exp = exp_q.pop_front();
        if (rd_row_o !== exp) begin
          n_fail++;
          $display("FAIL %s row %0d: got %b expected %b", name, r, rd_row_o, exp);
        end
      end
    end
  endtask

  // Pulses start, optionally loads the last row in the same cycle, and times done_o
  task automatic run(input string name, input int k, input logic [8:0] b, input logic [8:0] s,
                     input logic w, input int abort_at, input int exp_cyc,
                     input bit with_load, input logic [M-1:0] ld_row);
    int cyc;
    @(negedge clk_i);
    start_i        = 1'b1;
    step_count_i   = GEN_W'(k);
    rule_birth_i   = b;
    rule_survive_i = s;
    wrap_i         = w;
    if (with_load) begin
      load_valid_i = 1'b1;
      load_row_i   = ld_row;
    end
    @(posedge clk_i);
    @(negedge clk_i);
    start_i      = 1'b0;
    load_valid_i = 1'b0;
    cyc = 1;
    if (k != 0) begin
      n_checks++;
      if (busy_o !== 1'b1 || load_ready_o !== 1'b0) begin
        n_fail++;
        $display("FAIL %s busy_at_start: busy=%b ready=%b expected 1/0", name, busy_o, load_ready_o);
      end
    end
    while (done_o !== 1'b1 && cyc < exp_cyc + 20) begin
      abort_i = (cyc == abort_at);
      @(posedge clk_i);
      @(negedge clk_i);
      cyc++;
    end
    abort_i = 1'b0;
    n_checks++;
    if (done_o !== 1'b1 || cyc != exp_cyc) begin
      n_fail++;
      $display("FAIL %s done_latency: done=%b at cycle %0d expected cycle %0d", name, done_o, cyc, exp_cyc);
    end
    n_checks++;
    if (busy_o !== 1'b0 || load_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL %s end_state: busy=%b ready=%b expected 0/1", name, busy_o, load_ready_o);
    end
    @(negedge clk_i);
    n_checks++;
    if (done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_width: done=%b one cycle later expected 0", name, done_o);
    end
  endtask

  task automatic check_gen(input string name, input int exp);
    n_checks++;
    if (gen_count_o !== GEN_W'(exp)) begin
      n_fail++;
      $display("FAIL %s gen_count: got %0d expected %0d", name, gen_count_o, exp);
    end
  endtask

  task automatic do_reset();
    reset_n_i    = 1'b0;
    load_valid_i = 1'b0;
    load_row_i   = '0;
    start_i      = 1'b0;
    step_count_i = '0;
    abort_i      = 1'b0;
    rule_birth_i = CONWAY_BIRTH;
    rule_survive_i = CONWAY_SURVIVE;
    wrap_i       = 1'b0;
    rd_row_idx_i = '0;
    repeat (3) @(negedge clk_i);
    reset_n_i = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (load_ready_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0 ||
        gen_count_o !== '0 || rd_row_o !== '0) begin
      n_fail++;
      $display("FAIL reset_values: ready=%b busy=%b done=%b gen=%0d rd=%b expected 1 0 0 0 0",
               load_ready_o, busy_o, done_o, gen_count_o, rd_row_o);
    end
`ifdef LIFE_POPCOUNT_EN
    n_checks++;
    if (pop_count_o !== '0) begin
      n_fail++;
      $display("FAIL reset_pop: got %0d expected 0", pop_count_o);
    end
`endif
  endtask

  task automatic test_blinker();
    clear_model();
    mgrid[1] = 8'b0000_0100; mgrid[2] = 8'b0000_0100; mgrid[3] = 8'b0000_0100;
    load_grid(N);
    for (int r = 0; r < N; r++) exp_rows[r] = '0;
    exp_rows[2] = 8'b0000_1110;
    push_expect();
    run("blinker_k1", 1, CONWAY_BIRTH, CONWAY_SURVIVE, 1'b0, 0, N + 1, 1'b0, '0);
    check_gen("blinker_k1", 1);
    check_grid("blinker_k1");
    load_grid(N);
    exp_rows = mgrid;
    push_expect();
    run("blinker_k2", 2, CONWAY_BIRTH, CONWAY_SURVIVE, 1'b0, 0, 2 * N + 1, 1'b0, '0);
    check_gen("blinker_k2", 2);
    check_grid("blinker_k2");
  endtask

  task automatic set_glider();
    clear_model();
    mgrid[0] = 8'b0000_0010;
    mgrid[1] = 8'b0000_0100;
    mgrid[2] = 8'b0000_0111;
  endtask

  // 96 generations move the glider 24 rows and 24 columns: a whole number of laps on 6x8
  task automatic test_glider();
    set_glider();
    load_grid(N);
    exp_rows = mgrid;
    push_expect();
    run("glider", 96, CONWAY_BIRTH, CONWAY_SURVIVE, 1'b1, 0, 96 * N + 1, 1'b0, '0);
    check_gen("glider", 96);
    check_grid("glider");
  endtask

  task automatic test_corners();
    clear_model();
    mgrid[0] = 8'b1000_0001;
    mgrid[N-1] = 8'b1000_0001;
    load_grid(N);
    exp_rows = mgrid;
    push_expect();
    run("corners_wrap", 1, CONWAY_BIRTH, CONWAY_SURVIVE, 1'b1, 0, N + 1, 1'b0, '0);
    check_grid("corners_wrap");
    load_grid(N);
    for (int r = 0; r < N; r++) exp_rows[r] = '0;
    push_expect();
    run("corners_dead", 1, CONWAY_BIRTH, CONWAY_SURVIVE, 1'b0, 0, N + 1, 1'b0, '0);
    check_grid("corners_dead");
  endtask

  task automatic test_custom_rule();
    clear_model();
    mgrid[2] = 8'b0000_1000;
    load_grid(N);
    for (int r = 0; r < N; r++) exp_rows[r] = '0;
    exp_rows[1] = 8'b0001_1100;
    exp_rows[2] = 8'b0001_0100;
    exp_rows[3] = 8'b0001_1100;
    push_expect();
    run("custom_rule", 1, 9'h002, 9'h000, 1'b0, 0, N + 1, 1'b0, '0);
    check_grid("custom_rule");
  endtask

  task automatic test_abort();
    set_glider();
    load_grid(N);
    for (int g = 0; g < 3; g++) model_step(CONWAY_BIRTH, CONWAY_SURVIVE, 1'b1);
    exp_rows = mgrid;
    push_expect();
    run("abort", 100, CONWAY_BIRTH, CONWAY_SURVIVE, 1'b1, 2 * N + 3, 3 * N + 1, 1'b0, '0);
    check_gen("abort", 3);
    check_grid("abort");
    push_expect();
    run("zero_steps", 0, CONWAY_BIRTH, CONWAY_SURVIVE, 1'b1, 0, 1, 1'b0, '0);
    check_gen("zero_steps", 3);
    check_grid("zero_steps");
  endtask

  task automatic test_back_to_back();
    logic [M-1:0] ld;
    clear_model();
    mgrid[N-1] = 8'b0011_1000;
    load_grid(N - 1);
    ld = mgrid[N-1];
    model_step(CONWAY_BIRTH, CONWAY_SURVIVE, 1'b0);
    exp_rows = mgrid;
    push_expect();
    run("load_with_start", 1, CONWAY_BIRTH, CONWAY_SURVIVE, 1'b0, 0, N + 1, 1'b1, ld);
    check_gen("load_with_start", 1);
    check_grid("load_with_start");
  endtask

  task automatic test_popcount();
    int k_exp;
    clear_model();
    mgrid[2] = 8'b0001_0000;
    load_grid(N);
`ifdef LIFE_POPCOUNT_EN
    k_exp = 1;
`else
    k_exp = 10;
`endif
    for (int r = 0; r < N; r++) exp_rows[r] = '0;
    push_expect();
    run("single_cell", 10, CONWAY_BIRTH, CONWAY_SURVIVE, 1'b0, 0, k_exp * N + 1, 1'b0, '0);
    check_gen("single_cell", k_exp);
`ifdef LIFE_POPCOUNT_EN
    n_checks++;
    if (pop_count_o !== '0) begin
      n_fail++;
      $display("FAIL single_cell pop_count: got %0d expected 0", pop_count_o);
    end
`endif
    check_grid("single_cell");
  endtask

  task automatic test_reset_mid_run();
    bit saw_done;
    set_glider();
    load_grid(N);
    @(negedge clk_i);
    start_i      = 1'b1;
    step_count_i = GEN_W'(50);
    wrap_i       = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    start_i  = 1'b0;
    saw_done = 1'b0;
    repeat (10) begin
      @(negedge clk_i);
      if (done_o) saw_done = 1'b1;
    end
    reset_n_i = 1'b0;
    #1;
    n_checks++;
    if (busy_o !== 1'b0 || load_ready_o !== 1'b1 || gen_count_o !== '0 || saw_done) begin
      n_fail++;
      $display("FAIL reset_mid_run: busy=%b ready=%b gen=%0d early_done=%b expected 0 1 0 0",
               busy_o, load_ready_o, gen_count_o, saw_done);
    end
    repeat (2) @(negedge clk_i);
    reset_n_i = 1'b1;
    repeat (N + 2) begin
      @(negedge clk_i);
      if (done_o) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done) begin
      n_fail++;
      $display("FAIL reset_mid_run_done: done pulsed after reset, expected none");
    end
    for (int r = 0; r < N; r++) exp_rows[r] = '0;
    push_expect();
    check_grid("reset_mid_run");
  endtask

  initial begin
    test_reset();
    test_blinker();
    test_glider();
    test_corners();
    test_custom_rule();
    test_abort();
    test_back_to_back();
    test_popcount();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
